// File: rtl/druaga_vram_pkg.sv
// Shared constants for the BG VRAM time-slot arbiter: pixel slots, CPU port IDs,
// and the byte-lane select bit of the CPU address.
package druaga_vram_pkg;

   typedef enum logic [1:0] {
      SLOT_VID = 2'd0,
      SLOT_C1  = 2'd1,
      SLOT_C2  = 2'd2,
      SLOT_C3  = 2'd3
   } slot_e;

   typedef enum logic {
      PORT_M = 1'b0,
      PORT_S = 1'b1
   } port_e;

   localparam int LANE_BIT = 11;

   function automatic logic [1:0] lane_we(input logic lane);
      return {lane, ~lane};
   endfunction

endpackage

// File: rtl/druaga_rr2.sv
// Two-way round-robin picker; the pointer remembers the last port granted so
// the other one wins the next tie.
module druaga_rr2
   import druaga_vram_pkg::*;
(
   input  logic       VCLKx4,
   input  logic       RESET,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   port_e last;

   always_comb begin
      grant = req;
      if (req == 2'b11) grant = (last == PORT_S) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge VCLKx4 or posedge RESET) begin
      if (RESET)                  last <= PORT_S;
      else if (advance && |grant) last <= port_e'(grant[1]);
   end

endmodule

// File: rtl/druaga_vram_arbiter.sv
// Time-slot arbiter for the 2Kx16 BG VRAM: one video fetch per pixel, the other
// three slots shared round-robin between the main and sub CPU REQ/ACK ports.
//
// slot     | meaning (slot whose MEM_* issue is being decided this cycle)
// SLOT_VID | video fetch of VID_A; PSYNC forces this slot
// SLOT_C1  | first CPU slot
// SLOT_C2  | second CPU slot
// SLOT_C3  | third CPU slot
module druaga_vram_arbiter
   import druaga_vram_pkg::*;
#(
   parameter logic [10:0] ADDR_MASK = 11'h7FF
) (
   input  logic        VCLKx4,
   input  logic        RESET,
   input  logic        PSYNC,
   input  logic [10:0] VID_A,
   output logic [15:0] VID_D,
   input  logic        M_REQ,
   input  logic        M_WE,
   input  logic [11:0] M_A,
   input  logic [7:0]  M_D,
   output logic [7:0]  M_Q,
   output logic        M_ACK,
   input  logic        S_REQ,
   input  logic        S_WE,
   input  logic [11:0] S_A,
   input  logic [7:0]  S_D,
   output logic [7:0]  S_Q,
   output logic        S_ACK,
   output logic [10:0] MEM_A,
   output logic [15:0] MEM_D,
   output logic [1:0]  MEM_WE,
   input  logic [15:0] MEM_Q
);

   slot_e       ph, slot, ph_next;
   logic        cpu_slot, grant_vld, m_busy, s_busy;
   logic [1:0]  qual, grant;
   port_e       grant_port;
   logic [11:0] g_a;
   logic [7:0]  g_d;
   logic        g_we;

   logic        iss_vld, iss_lane, iss_we, iss_vid;
   port_e       iss_port;
   logic        rd_vld, rd_lane, rd_we, rd_vid;
   port_e       rd_port;

   // a port stays busy from its grant until its ACK cycle
   assign m_busy = (iss_vld && iss_port == PORT_M) || (rd_vld && rd_port == PORT_M) || M_ACK;
   assign s_busy = (iss_vld && iss_port == PORT_S) || (rd_vld && rd_port == PORT_S) || S_ACK;

   always_ff @(posedge VCLKx4 or posedge RESET) begin
      if (RESET) ph <= SLOT_VID;
      else       ph <= ph_next;
   end

   always_comb begin
      slot     = PSYNC ? SLOT_VID : ph;
      ph_next  = slot_e'(2'(slot + 2'd1));
      cpu_slot = (slot == SLOT_C1) || (slot == SLOT_C2) || (slot == SLOT_C3);
      qual     = 2'b00;
      if (cpu_slot) qual = {S_REQ & ~s_busy, M_REQ & ~m_busy};
   end

   druaga_rr2 u_rr2 (
      .VCLKx4  (VCLKx4),
      .RESET   (RESET),
      .req     (qual),
      .advance (cpu_slot),
      .grant   (grant)
   );

   always_comb begin
      grant_vld  = |grant;
      grant_port = port_e'(grant[1]);
      g_a        = grant[1] ? S_A  : M_A;
      g_d        = grant[1] ? S_D  : M_D;
      g_we       = grant[1] ? S_WE : M_WE;
   end

   always_ff @(posedge VCLKx4 or posedge RESET) begin
      if (RESET) begin
         MEM_A    <= '0;
         MEM_D    <= '0;
         MEM_WE   <= '0;
         iss_vld  <= 1'b0;
         iss_port <= PORT_M;
         iss_lane <= 1'b0;
         iss_we   <= 1'b0;
         iss_vid  <= 1'b0;
      end else begin
         MEM_WE   <= 2'b00;
         iss_vld  <= grant_vld;
         iss_port <= grant_port;
         iss_lane <= g_a[LANE_BIT];
         iss_we   <= g_we;
         iss_vid  <= (slot == SLOT_VID);
         if (slot == SLOT_VID) begin
            MEM_A <= VID_A & ADDR_MASK;
         end else if (grant_vld) begin
            MEM_A <= g_a[10:0] & ADDR_MASK;
            MEM_D <= {g_d, g_d};
            if (g_we) MEM_WE <= lane_we(g_a[LANE_BIT]);
         end
      end
   end

   always_ff @(posedge VCLKx4 or posedge RESET) begin
      if (RESET) begin
         rd_vld  <= 1'b0;
         rd_port <= PORT_M;
         rd_lane <= 1'b0;
         rd_we   <= 1'b0;
         rd_vid  <= 1'b0;
      end else begin
         rd_vld  <= iss_vld;
         rd_port <= iss_port;
         rd_lane <= iss_lane;
         rd_we   <= iss_we;
         rd_vid  <= iss_vid;
      end
   end

   // MEM_Q is valid in the rd stage; video and CPU captures are independent
   always_ff @(posedge VCLKx4 or posedge RESET) begin
      if (RESET) begin
         M_ACK <= 1'b0;
         S_ACK <= 1'b0;
         M_Q   <= '0;
         S_Q   <= '0;
         VID_D <= '0;
      end else begin
         M_ACK <= rd_vld && rd_port == PORT_M;
         S_ACK <= rd_vld && rd_port == PORT_S;
         if (rd_vld && !rd_we) begin
            if (rd_port == PORT_M) M_Q <= rd_lane ? MEM_Q[15:8] : MEM_Q[7:0];
            else                   S_Q <= rd_lane ? MEM_Q[15:8] : MEM_Q[7:0];
         end
         if (rd_vid) VID_D <= MEM_Q;
      end
   end

endmodule

// File: tb/tb_druaga_vram_arbiter.sv
// Scoreboard bench for druaga_vram_arbiter: a slot/busy/round-robin reference
// model queues expected MEM issues, ACKs and VID_D updates; a monitor compares.
module tb_druaga_vram_arbiter;

   localparam logic [10:0] MASK = 11'h3FF;

   logic        VCLKx4 = 1'b0;
   logic        RESET = 1'b1;
   logic        PSYNC = 1'b0;
   logic [10:0] VID_A = '0;
   logic [15:0] VID_D;
   logic        M_REQ = 1'b0, M_WE = 1'b0;
   logic [11:0] M_A = '0;
   logic [7:0]  M_D = '0;
   logic [7:0]  M_Q;
   logic        M_ACK;
   logic        S_REQ = 1'b0, S_WE = 1'b0;
   logic [11:0] S_A = '0;
   logic [7:0]  S_D = '0;
   logic [7:0]  S_Q;
   logic        S_ACK;
   logic [10:0] MEM_A;
   logic [15:0] MEM_D;
   logic [1:0]  MEM_WE;
   logic [15:0] MEM_Q = '0;

   druaga_vram_arbiter #(.ADDR_MASK(MASK)) dut (
      .VCLKx4(VCLKx4), .RESET(RESET), .PSYNC(PSYNC),
      .VID_A(VID_A), .VID_D(VID_D),
      .M_REQ(M_REQ), .M_WE(M_WE), .M_A(M_A), .M_D(M_D), .M_Q(M_Q), .M_ACK(M_ACK),
      .S_REQ(S_REQ), .S_WE(S_WE), .S_A(S_A), .S_D(S_D), .S_Q(S_Q), .S_ACK(S_ACK),
      .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_WE(MEM_WE), .MEM_Q(MEM_Q)
   );

   always #5 VCLKx4 = ~VCLKx4;

   longint cyc = 0;
   always @(posedge VCLKx4) cyc <= cyc + 1;

   // VRAM macro: one-cycle synchronous read, byte write enables
   logic [15:0] vram [2048];
   always @(posedge VCLKx4) begin
      MEM_Q <= vram[MEM_A];
      if (MEM_WE[0]) vram[MEM_A][7:0]  = MEM_D[7:0];
      if (MEM_WE[1]) vram[MEM_A][15:8] = MEM_D[15:8];
   end

   // kind: 0 video, 1 cpu read, 2 cpu write, 3 idle slot
   typedef struct { longint cyc; int kind; logic [10:0] a; logic [1:0] we; logic [15:0] d; } iss_t;
   typedef struct { longint cyc; bit chk_q; logic [7:0] q; } ack_t;
   typedef struct { longint cyc; logic [15:0] d; } vid_t;

   iss_t iss_q[$];
   ack_t m_ack_q[$];
   ack_t s_ack_q[$];
   vid_t vid_q[$];

   logic [15:0] ref_mem [2048];
   int          ph;
   int          last;
   longint      busy_until [2];
   bit          run = 0;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      ph = 0;
      last = 1;
      busy_until[0] = -1;
      busy_until[1] = -1;
   endtask

   function automatic iss_t mk_iss(longint c, int k, logic [10:0] a, logic [1:0] we, logic [15:0] d);
      iss_t e;
      e.cyc = c; e.kind = k; e.a = a; e.we = we; e.d = d;
      return e;
   endfunction

   function automatic ack_t mk_ack(longint c, bit chkq, logic [7:0] q);
      ack_t e;
      e.cyc = c; e.chk_q = chkq; e.q = q;
      return e;
   endfunction

   // reference: decision this cycle -> issue next cycle, ACK / VID_D three cycles on
   task automatic model_step();
      int          slot, p;
      bit [1:0]    el;
      logic [11:0] a;
      logic [7:0]  d;
      logic        we;
      logic [10:0] w;
      vid_t        v;
      slot = PSYNC ? 0 : ph;
      ph = (slot + 1) % 4;
      if (slot == 0) begin
         w = VID_A & MASK;
         iss_q.push_back(mk_iss(cyc + 1, 0, w, 2'b00, 16'h0));
         v.cyc = cyc + 3; v.d = ref_mem[w];
         vid_q.push_back(v);
      end else begin
         el[0] = M_REQ && (cyc > busy_until[0]);
         el[1] = S_REQ && (cyc > busy_until[1]);
         if (el == 2'b00) begin
            iss_q.push_back(mk_iss(cyc + 1, 3, 11'h0, 2'b00, 16'h0));
         end else begin
            if (el == 2'b11) p = 1 - last;
            else             p = el[1] ? 1 : 0;
            last = p;
            busy_until[p] = cyc + 3;
            a  = p ? S_A  : M_A;
            d  = p ? S_D  : M_D;
            we = p ? S_WE : M_WE;
            w  = a[10:0] & MASK;
            if (we) begin
               iss_q.push_back(mk_iss(cyc + 1, 2, w, a[11] ? 2'b10 : 2'b01, {d, d}));
               if (a[11]) ref_mem[w][15:8] = d;
               else       ref_mem[w][7:0]  = d;
               if (p == 1) s_ack_q.push_back(mk_ack(cyc + 3, 1'b0, 8'h0));
               else        m_ack_q.push_back(mk_ack(cyc + 3, 1'b0, 8'h0));
            end else begin
               iss_q.push_back(mk_iss(cyc + 1, 1, w, 2'b00, 16'h0));
               d = a[11] ? ref_mem[w][15:8] : ref_mem[w][7:0];
               if (p == 1) s_ack_q.push_back(mk_ack(cyc + 3, 1'b1, d));
               else        m_ack_q.push_back(mk_ack(cyc + 3, 1'b1, d));
            end
         end
      end
   endtask

   task automatic chk_port(input string nm, input bit is_s, input logic ack, input logic [7:0] q);
      ack_t e;
      bit   exp;
      exp = 0;
      e = mk_ack(0, 1'b0, 8'h0);
      if (is_s) begin
         if (s_ack_q.size() > 0 && s_ack_q[0].cyc == cyc) begin exp = 1; e = s_ack_q.pop_front(); end
      end else begin
         if (m_ack_q.size() > 0 && m_ack_q[0].cyc == cyc) begin exp = 1; e = m_ack_q.pop_front(); end
      end
      chk({nm, "_ACK"}, {15'h0, ack}, {15'h0, exp});
      if (exp && e.chk_q) chk({nm, "_Q"}, {8'h0, q}, {8'h0, e.q});
   endtask

   iss_t mon_i;
   vid_t mon_v;
   always @(negedge VCLKx4) begin
      if (run && !RESET) begin
         if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
            mon_i = iss_q.pop_front();
            chk("MEM_WE", {14'h0, MEM_WE}, {14'h0, mon_i.we});
            if (mon_i.kind != 3) chk("MEM_A", {5'h0, MEM_A}, {5'h0, mon_i.a});
            if (mon_i.kind == 2) chk("MEM_D", MEM_D, mon_i.d);
         end
         chk_port("M", 1'b0, M_ACK, M_Q);
         chk_port("S", 1'b1, S_ACK, S_Q);
         if (vid_q.size() > 0 && vid_q[0].cyc == cyc) begin
            mon_v = vid_q.pop_front();
            chk("VID_D", VID_D, mon_v.d);
         end
      end
   end

   task automatic wait_cycle();
      @(posedge VCLKx4);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_MEM_WE", {14'h0, MEM_WE}, 16'h0);
      chk("rst_MEM_A",  {5'h0, MEM_A}, 16'h0);
      chk("rst_MEM_D",  MEM_D, 16'h0);
      chk("rst_VID_D",  VID_D, 16'h0);
      chk("rst_ACK",    {14'h0, M_ACK, S_ACK}, 16'h0);
      chk("rst_Q",      {M_Q, S_Q}, 16'h0);
   endtask

   // mid-stream reset: pending expectations are void, memory model resyncs to the RAM
   task automatic do_reset();
      RESET = 1'b1;
      run = 0;
      iss_q.delete(); m_ack_q.delete(); s_ack_q.delete(); vid_q.delete();
      #1;
      chk_reset_outputs();
      wait_cycle();
      wait_cycle();
      RESET = 1'b0;
      ref_mem = vram;
      model_reset();
      run = 1;
   endtask

   task automatic rand_inputs(input int mode_m, input int mode_s);
      PSYNC = ($urandom_range(0, 15) == 0);
      VID_A = 11'($urandom);
      M_REQ = ($urandom_range(0, 3) < mode_m);
      M_WE  = 1'($urandom);
      M_A   = {1'($urandom), 1'($urandom), 6'h0, 4'($urandom)};
      M_D   = 8'($urandom);
      S_REQ = ($urandom_range(0, 3) < mode_s);
      S_WE  = 1'($urandom);
      S_A   = {1'($urandom), 1'($urandom), 6'h0, 4'($urandom)};
      S_D   = 8'($urandom);
   endtask

   initial begin
      int mode_m, mode_s;
      for (int i = 0; i < 2048; i++) vram[i] = 16'($urandom);
      vram[5] = 16'hAB12;
      ref_mem = vram;
      model_reset();
      repeat (2) wait_cycle();
      chk_reset_outputs();
      wait_cycle();
      RESET = 1'b0;
      run = 1;

      // directed: PSYNC video, main read of 805, sub write of 5C to 010
      PSYNC = 1'b1; VID_A = 11'h7A5;
      model_step();
      wait_cycle();
      PSYNC = 1'b0;
      M_REQ = 1'b1; M_WE = 1'b0; M_A = 12'h805;
      S_REQ = 1'b1; S_WE = 1'b1; S_A = 12'h010; S_D = 8'h5C;
      model_step();
      wait_cycle();
      M_REQ = 1'b0;
      model_step();
      wait_cycle();
      S_REQ = 1'b0;
      model_step();
      // mask: main read at 7FF lands on 3FF
      for (int i = 0; i < 6; i++) begin
         wait_cycle();
         M_REQ = (i == 0); M_A = 12'h7FF; M_WE = 1'b0;
         model_step();
      end

      mode_m = 4; mode_s = 4;
      for (int i = 0; i < 3000; i++) begin
         wait_cycle();
         if (i % 1000 == 999) do_reset();
         if (i % 150 == 0 && i > 0) begin
            mode_m = $urandom_range(0, 4);
            mode_s = $urandom_range(0, 4);
         end
         rand_inputs(mode_m, mode_s);
         model_step();
      end

      for (int i = 0; i < 8; i++) begin
         wait_cycle();
         PSYNC = 1'b0; M_REQ = 1'b0; S_REQ = 1'b0;
         model_step();
      end
      repeat (4) wait_cycle();
      #5;
      chk("drain_iss", 16'(iss_q.size()), 16'h0);
      chk("drain_ack", 16'(m_ack_q.size() + s_ack_q.size()), 16'h0);
      chk("drain_vid", 16'(vid_q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
